// File: rtl/half_adder_structural.sv
// ---------------------------------------------------------------------------
// half_adder_structural
//
// Purpose:
//   A vector of WIDTH independent half-adder lanes built only from 2-input
//   NAND gate primitives, with an optional output register stage. It is a
//   leaf arithmetic cell for full adders and for ripple and carry-save
//   structures. Lanes do not interact, and no carry passes between them.
//
//   Per lane:
//     {carry[i], sum[i]} = a[i] + b[i]
//     sum[i]   = a[i] XOR b[i]  (four NANDs)
//     carry[i] = a[i] AND b[i]  (two NANDs; the first NAND is shared with sum)
//
// Parameters:
//   WIDTH   - number of independent lanes. The supported range is 1 to 64.
//   OUT_REG - 1: sum and carry are registered on the rising edge of clk.
//                This gives a latency of one cycle and a throughput of one
//                operand pair per cycle. An asynchronous, active-low reset
//                clears both outputs.
//             0: the outputs are purely combinational. clk and rst_n are
//                ignored.
//
// Ports:
//   clk    in   1      rising-edge clock for the output register stage
//   rst_n  in   1      asynchronous active-low reset of the output registers
//   a      in   WIDTH  addend A, one bit per lane
//   b      in   WIDTH  addend B, one bit per lane
//   sum    out  WIDTH  per-lane sum bit   (a ^ b)
//   carry  out  WIDTH  per-lane carry bit (a & b)
//
// Handshake:
//   There is no valid/ready handshake. In registered mode, each rising edge
//   captures one new operand pair. Its result is visible on the following
//   cycle. sum and carry are never both 1 in the same lane.
// ---------------------------------------------------------------------------
module half_adder_structural #(
    parameter int WIDTH   = 1,
    parameter bit OUT_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    // Raw gate-network outputs, one bit per lane.
    logic [WIDTH-1:0] sum_net;
    logic [WIDTH-1:0] carry_net;

    // Next-state values for the output register stage.
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] carry_d;

    // -----------------------------------------------------------------------
    // Structural datapath.
    // Each lane reads only its own a[i] and b[i]. An X or Z on one lane
    // therefore stays in that lane.
    // -----------------------------------------------------------------------
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic n1;  // NAND(a,b); shared by the XOR and AND paths
        logic n2;  // NAND(a,n1)
        logic n3;  // NAND(b,n1)

        nand u_n1 (n1, a[i], b[i]);
        nand u_n2 (n2, a[i], n1);
        nand u_n3 (n3, b[i], n1);
        nand u_s  (sum_net[i], n2, n3);

        // Feeding n1 to both inputs turns this NAND into an inverter,
        // so the output is a & b.
        nand u_c  (carry_net[i], n1, n1);
    end : g_lane

    always_comb begin
        sum_d   = sum_net;
        carry_d = carry_net;
    end

    // -----------------------------------------------------------------------
    // Output stage
    // -----------------------------------------------------------------------
    if (OUT_REG) begin : g_reg
        logic [WIDTH-1:0] sum_q;
        logic [WIDTH-1:0] carry_q;

        // The reset is asynchronous. Any result still in flight is discarded
        // as soon as rst_n falls, without waiting for a clock edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q   <= '0;
                carry_q <= '0;
            end else begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
            end
        end

        assign sum   = sum_q;
        assign carry = carry_q;
    end else begin : g_comb
        // Combinational mode has no state, so the clock and reset are
        // intentionally left unconnected to any logic.
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, clk, rst_n};

        assign sum   = sum_d;
        assign carry = carry_d;
    end

endmodule : half_adder_structural

// File: tb/tb_half_adder_structural.sv
module tb_half_adder_structural;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // DUT instances
    // ------------------------------------------------------------------
    logic       c1_a, c1_b, c1_s, c1_c;   // WIDTH=1, combinational
    logic       r1_a, r1_b, r1_s, r1_c;   // WIDTH=1, registered
    logic [7:0] r8_a, r8_b, r8_s, r8_c;   // WIDTH=8, registered
    logic [3:0] r4_a, r4_b, r4_s, r4_c;   // WIDTH=4, registered
    logic [3:0] c4_s, c4_c;               // WIDTH=4, combinational (shares r4 inputs)

    half_adder_structural #(.WIDTH(1), .OUT_REG(1'b0)) u_c1 (
        .clk(clk), .rst_n(rst_n), .a(c1_a), .b(c1_b), .sum(c1_s), .carry(c1_c));
    half_adder_structural #(.WIDTH(1), .OUT_REG(1'b1)) u_r1 (
        .clk(clk), .rst_n(rst_n), .a(r1_a), .b(r1_b), .sum(r1_s), .carry(r1_c));
    half_adder_structural #(.WIDTH(8), .OUT_REG(1'b1)) u_r8 (
        .clk(clk), .rst_n(rst_n), .a(r8_a), .b(r8_b), .sum(r8_s), .carry(r8_c));
    half_adder_structural #(.WIDTH(4), .OUT_REG(1'b1)) u_r4 (
        .clk(clk), .rst_n(rst_n), .a(r4_a), .b(r4_b), .sum(r4_s), .carry(r4_c));
    half_adder_structural #(.WIDTH(4), .OUT_REG(1'b0)) u_c4 (
        .clk(clk), .rst_n(rst_n), .a(r4_a), .b(r4_b), .sum(c4_s), .carry(c4_c));

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];   // {carry[7:0], sum[7:0]}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each lane is an independent 1-bit + 1-bit addition.
    // The 2-bit result 0..2 is split into its low bit (sum) and high bit (carry).
    function automatic logic [15:0] ref_add(input logic [7:0] a, input logic [7:0] b, input int w);
        logic [7:0] s;
        logic [7:0] c;
        s = '0;
        c = '0;
        for (int i = 0; i < w; i++) begin
            int t;
            t = (a[i] ? 1 : 0) + (b[i] ? 1 : 0);
            s[i] = (t % 2) == 1;
            c[i] = (t / 2) == 1;
        end
        return {c, s};
    endfunction

    // ------------------------------------------------------------------
    // Vector tables
    // ------------------------------------------------------------------
    typedef struct {
        logic a;
        logic b;
        logic s;
        logic c;
    } vec_t;

    vec_t tt[4];

    // ------------------------------------------------------------------
    // Driver / test sequence
    // ------------------------------------------------------------------
    initial begin
        logic [15:0] e;

        tt[0] = '{a: 1'b0, b: 1'b0, s: 1'b0, c: 1'b0};
        tt[1] = '{a: 1'b0, b: 1'b1, s: 1'b1, c: 1'b0};
        tt[2] = '{a: 1'b1, b: 1'b0, s: 1'b1, c: 1'b0};
        tt[3] = '{a: 1'b1, b: 1'b1, s: 1'b0, c: 1'b1};

        rst_n = 1'b0;
        c1_a = 0; c1_b = 0;
        r1_a = 0; r1_b = 0;
        r8_a = '0; r8_b = '0;
        r4_a = '0; r4_b = '0;

        @(posedge clk); #1;

        // 1. Combinational truth table. rst_n is low here, which must not matter.
        for (int k = 0; k < 4; k++) begin
            c1_a = tt[k].a; c1_b = tt[k].b;
            #10;
            check($sformatf("comb_sum[%0d]", k), 64'(c1_s), 64'(tt[k].s));
            check($sformatf("comb_carry[%0d]", k), 64'(c1_c), 64'(tt[k].c));
        end

        // 2. Reset holds the registered outputs at 0 while ab=11.
        r1_a = 1; r1_b = 1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("rst_hold_sum", 64'(r1_s), 64'd0);
            check("rst_hold_carry", 64'(r1_c), 64'd0);
        end
        check("rst_r8", {48'd0, r8_c, r8_s}, 64'd0);
        rst_n = 1'b1;
        #2;
        check("rst_release_pre_edge_carry", 64'(r1_c), 64'd0);
        @(posedge clk); #1;
        check("first_edge_sum", 64'(r1_s), 64'd0);
        check("first_edge_carry", 64'(r1_c), 64'd1);

        // 3. Registered pipeline: each result appears one edge after its inputs.
        for (int k = 0; k < 4; k++) begin
            r1_a = tt[k].a; r1_b = tt[k].b;
            @(posedge clk); #1;
            check($sformatf("pipe_sum[%0d]", k), 64'(r1_s), 64'(tt[k].s));
            check($sformatf("pipe_carry[%0d]", k), 64'(r1_c), 64'(tt[k].c));
            check("pipe_not_both", 64'(r1_s & r1_c), 64'd0);
        end

        // 4. Asynchronous reset in the middle of the stream. ab=11 and carry=1 here.
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_carry", 64'(r1_c), 64'd0);
        check("async_rst_sum", 64'(r1_s), 64'd0);
        #2;
        rst_n = 1'b1;
        #1;
        check("async_rst_still0", 64'(r1_c), 64'd0);
        @(posedge clk); #1;
        check("async_rel_carry", 64'(r1_c), 64'd1);
        // Inputs that change between edges must not reach the output until the next edge.
        r1_a = 0; r1_b = 0;
        #3;
        check("hold_between_edges", 64'(r1_c), 64'd1);
        @(posedge clk); #1;
        check("hold_next_edge", 64'(r1_c), 64'd0);

        // 5. WIDTH=8 directed vectors.
        r8_a = 8'hF0; r8_b = 8'hCC;
        @(posedge clk); #1;
        check("w8_sum_F0_CC", 64'(r8_s), 64'h3C);
        check("w8_carry_F0_CC", 64'(r8_c), 64'hC0);
        r8_a = 8'hFF; r8_b = 8'h00;
        @(posedge clk); #1;
        check("w8_sum_FF_00", 64'(r8_s), 64'hFF);
        check("w8_carry_FF_00", 64'(r8_c), 64'h00);
        r8_a = 8'hFF; r8_b = 8'hFF;
        @(posedge clk); #1;
        check("w8_sum_FF_FF", 64'(r8_s), 64'h00);
        check("w8_carry_FF_FF", 64'(r8_c), 64'hFF);

        // WIDTH=8 random stream, checked through the expected queue.
        for (int k = 0; k < 200; k++) begin
            r8_a = 8'($urandom_range(0, 255));
            r8_b = 8'($urandom_range(0, 255));
            exp_q.push_back(ref_add(r8_a, r8_b, 8));
            @(posedge clk); #1;
            if (exp_q.size() == 0) begin
                check("w8_rand_queue_empty", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("w8_rand", {48'd0, r8_c, r8_s}, 64'(e));
            end
        end

        // 6. WIDTH=4 exhaustive, registered and combinational.
        for (int p = 0; p < 256; p++) begin
            r4_a = 4'(p >> 4);
            r4_b = 4'(p);
            exp_q.push_back(ref_add({4'd0, r4_a}, {4'd0, r4_b}, 4));
            #2;
            e = ref_add({4'd0, r4_a}, {4'd0, r4_b}, 4);
            check("w4_comb", {56'd0, c4_c, c4_s}, {56'd0, e[11:8], e[3:0]});
            @(posedge clk); #1;
            if (exp_q.size() == 0) begin
                check("w4_reg_queue_empty", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("w4_reg", {56'd0, r4_c, r4_s}, {56'd0, e[11:8], e[3:0]});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_half_adder_structural

// File: doc/half_adder_structural.md
Name: half_adder_structural

Overview:
- Gate-level (structural) half adder: per lane, sum = a XOR b, carry = a AND b.
- The logic is built only from instantiated 2-input NAND primitives, followed by an optional output register stage.
- Used as a leaf arithmetic cell feeding full adders and ripple/carry-save structures.
- A vector of WIDTH independent lanes; there is no carry chain between lanes.

Parameters:
- WIDTH, 1, number of independent half-adder lanes (range 1 to 64).
- OUT_REG, 1, 1 = sum/carry registered on clk (1-cycle latency); 0 = purely combinational outputs, with clk/rst_n unused.

Ports:
- clk  input  1  rising-edge clock for the output register stage.
- rst_n  input  1  asynchronous, active-low reset; clears the output registers.
- a  input  WIDTH  addend A, one bit per lane.
- b  input  WIDTH  addend B, one bit per lane.
- sum  output  WIDTH  per-lane sum bit, a[i] XOR b[i].
- carry  output  WIDTH  per-lane carry bit, a[i] AND b[i].

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Per-lane logic is structural only, with no behavioural operators in the datapath.
- XOR is formed from 4 NANDs:
  - n1 = NAND(a,b)
  - n2 = NAND(a,n1)
  - n3 = NAND(b,n1)
  - s = NAND(n2,n3)
- AND is formed from 2 NANDs: c = NAND(n1,n1). n1 is shared between the sum and carry paths.
- Lanes are generated with a generate loop; lane i uses only a[i] and b[i].
- Arithmetic rule: {carry[i], sum[i]} = a[i] + b[i], a 2-bit result in the range 0..2.
- Truth table per lane:
  - 00 -> s0 c0
  - 01 -> s1 c0
  - 10 -> s1 c0
  - 11 -> s0 c1
- sum and carry are never both 1.
- OUT_REG=1:
  - sum/carry are captured on each rising clk edge.
  - Latency is exactly 1 cycle; throughput is one new operand pair per cycle.
  - rst_n low forces sum=0 and carry=0 immediately, without waiting for a clock edge.
  - Outputs hold 0 while rst_n is low.
  - The first capture happens on the first rising clk edge after rst_n deasserts.
  - Reset asserted mid-stream discards any pending result; outputs go to 0 at once.
  - Inputs that change between edges do not affect the outputs until the next edge.
- OUT_REG=0:
  - Outputs follow the inputs after gate delay only; there is no state.
  - rst_n has no effect.
- X/Z on a lane input may propagate to that lane's outputs only; other lanes are unaffected.
- No handshake, no valid signalling, no overflow condition: the carry is the only out-of-range indicator.

Test Plan:
1. WIDTH=1, OUT_REG=0:
   - Apply ab = 00, 01, 10, 11, holding each for 10 time units.
   - Required after each settle: sum/carry = 0/0, 1/0, 1/0, 0/1.
2. WIDTH=1, OUT_REG=1:
   - Hold rst_n=0 with ab=11 and toggle clk: sum=0, carry=0 throughout.
   - Release rst_n: on the 1st rising edge, sum=0, carry=1.
3. WIDTH=1, OUT_REG=1, pipelined latency:
   - Apply 00, 01, 10, 11 on successive edges.
   - Outputs trail by exactly one edge: 0/0, 1/0, 1/0, 0/1.
   - The output never shows sum=1 together with carry=1.
4. Asynchronous reset mid-stream, OUT_REG=1, ab=11 with carry=1:
   - Drop rst_n between clock edges: carry goes to 0 immediately, before the next edge.
   - Raise rst_n: carry returns to 1 on the next edge.
5. WIDTH=8, OUT_REG=1:
   - Apply a=8'hF0, b=8'hCC: after 1 edge, sum=8'h3C, carry=8'hC0.
   - Apply a=8'hFF, b=8'h00: sum=8'hFF, carry=8'h00.
6. WIDTH=4, exhaustive:
   - Apply all 256 (a,b) pairs.
   - For every lane, the scoreboard check {carry[i], sum[i]} == a[i] + b[i] passes, with no cross-lane interaction.
